// File: rtl/hilo_ctrl.sv
// HI/LO register controller: sequences MULT through an external multi-cycle multiplier and services MTHI/MTLO.
// Optional macro HILO_FWD_EN forwards the product onto rd_data during CAPTURE and drops busy one cycle early.
module hilo_ctrl #(
    parameter int MUL_LAT = 18,
    parameter int W       = 16
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           op_valid,
    input  logic [1:0]     op_sel,
    input  logic [W-1:0]   rs_data,
    input  logic [W-1:0]   rt_data,
    output logic           op_ready,
    output logic           mul_start,
    output logic [W-1:0]   mul_a,
    output logic [W-1:0]   mul_b,
    input  logic [2*W-1:0] mul_produto,
    input  logic           rd_sel,
    output logic [W-1:0]   rd_data,
    output logic           busy
);

    localparam int CW = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;

    localparam logic [1:0] OP_MULT = 2'b00;
    localparam logic [1:0] OP_MTHI = 2'b01;
    localparam logic [1:0] OP_MTLO = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_START   = 2'd1,
        S_WAIT    = 2'd2,
        S_CAPTURE = 2'd3
    } state_t;

    state_t        state_r;
    state_t        state_s;
    logic [CW-1:0] cnt_r;
    logic [CW-1:0] cnt_s;
    logic [W-1:0]  hi_r;
    logic [W-1:0]  lo_r;
    logic [W-1:0]  mul_a_r;
    logic [W-1:0]  mul_b_r;
    logic          mul_start_r;
    logic          busy_r;
    logic          op_ready_r;
    logic          mul_start_s;
    logic          busy_s;
    logic          op_ready_s;
    logic          accept_s;

    assign accept_s = op_valid && op_ready_r && (state_r == S_IDLE);

    // State and cycle-counter register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= S_IDLE;
            cnt_r   <= {CW{1'b0}};
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
        end
    end

    // Next-state and counter logic; the counter saturates at zero
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r;
        case (state_r)
            S_IDLE: begin
                if (accept_s && (op_sel == OP_MULT)) begin
                    state_s = S_START;
                end else begin
                    state_s = S_IDLE;
                end
            end
            S_START: begin
                state_s = S_WAIT;
                cnt_s   = CW'(MUL_LAT - 1);
            end
            S_WAIT: begin
                if (cnt_r == {CW{1'b0}}) begin
                    state_s = S_CAPTURE;
                end else begin
                    state_s = S_WAIT;
                    cnt_s   = cnt_r - CW'(1);
                end
            end
            S_CAPTURE: begin
                state_s = S_IDLE;
            end
            default: begin
                state_s = S_IDLE;
                cnt_s   = {CW{1'b0}};
            end
        endcase
    end

    // Output decode from the next state so the handshake outputs come straight from flops
    always_comb begin
        mul_start_s = (state_s == S_START);
        op_ready_s  = (state_s == S_IDLE);
`ifdef HILO_FWD_EN
        busy_s      = (state_s == S_START) || ((state_s == S_WAIT) && (cnt_s != {CW{1'b0}}));
`else
        busy_s      = (state_s == S_START) || (state_s == S_WAIT);
`endif
    end

    // Registered handshake outputs; op_ready resets high because reset lands in IDLE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mul_start_r <= 1'b0;
            busy_r      <= 1'b0;
            op_ready_r  <= 1'b1;
        end else begin
            mul_start_r <= mul_start_s;
            busy_r      <= busy_s;
            op_ready_r  <= op_ready_s;
        end
    end

    // Operand latch: held from START through CAPTURE since only an IDLE accept reloads it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mul_a_r <= {W{1'b0}};
            mul_b_r <= {W{1'b0}};
        end else if (accept_s && (op_sel == OP_MULT)) begin
            mul_a_r <= rs_data;
            mul_b_r <= rt_data;
        end else begin
            mul_a_r <= mul_a_r;
            mul_b_r <= mul_b_r;
        end
    end

    // HI/LO: full unsigned product on CAPTURE, direct writes for MTHI/MTLO
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hi_r <= {W{1'b0}};
            lo_r <= {W{1'b0}};
        end else if (state_r == S_CAPTURE) begin
            hi_r <= mul_produto[2*W-1:W];
            lo_r <= mul_produto[W-1:0];
        end else if (accept_s && (op_sel == OP_MTHI)) begin
            hi_r <= rs_data;
        end else if (accept_s && (op_sel == OP_MTLO)) begin
            lo_r <= rs_data;
        end else begin
            hi_r <= hi_r;
            lo_r <= lo_r;
        end
    end

    // Read mux
    always_comb begin
`ifdef HILO_FWD_EN
        if (state_r == S_CAPTURE) begin
            rd_data = rd_sel ? mul_produto[2*W-1:W] : mul_produto[W-1:0];
        end else begin
            rd_data = rd_sel ? hi_r : lo_r;
        end
`else
        rd_data = rd_sel ? hi_r : lo_r;
`endif
    end

    assign op_ready  = op_ready_r;
    assign mul_start = mul_start_r;
    assign busy      = busy_r;
    assign mul_a     = mul_a_r;
    assign mul_b     = mul_b_r;

endmodule

// File: tb/tb_hilo_ctrl.sv
// Directed bench for hilo_ctrl with a behavioural MUL_LAT-cycle multiplier that shows junk until the product is due.
module tb_hilo_ctrl;

    localparam int MUL_LAT = 18;
    localparam int W       = 16;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          op_valid;
    logic [1:0]    op_sel;
    logic [W-1:0]  rs_data;
    logic [W-1:0]  rt_data;
    logic          op_ready;
    logic          mul_start;
    logic [W-1:0]  mul_a;
    logic [W-1:0]  mul_b;
    logic [2*W-1:0] mul_produto;
    logic          rd_sel;
    logic [W-1:0]  rd_data;
    logic          busy;

    int vec_cnt = 0;
    int err_cnt = 0;

    hilo_ctrl #(.MUL_LAT(MUL_LAT), .W(W)) dut (
        .clk(clk), .rst_n(rst_n), .op_valid(op_valid), .op_sel(op_sel),
        .rs_data(rs_data), .rt_data(rt_data), .op_ready(op_ready),
        .mul_start(mul_start), .mul_a(mul_a), .mul_b(mul_b),
        .mul_produto(mul_produto), .rd_sel(rd_sel), .rd_data(rd_data), .busy(busy)
    );

    always #5 clk = ~clk;

    // Multiplier model: never reset, so an abandoned multiply still produces a late product
    int            mcnt = 0;
    logic [W-1:0]  ma = '0;
    logic [W-1:0]  mb = '0;
    logic [2*W-1:0] prod_q = 32'hDEADBEEF;
    assign mul_produto = prod_q;

    always @(posedge clk) begin
        if (mul_start) begin
            mcnt   <= MUL_LAT;
            ma     <= mul_a;
            mb     <= mul_b;
            prod_q <= 32'hDEADBEEF;
        end else if (mcnt > 1) begin
            mcnt <= mcnt - 1;
        end else if (mcnt == 1) begin
            mcnt   <= 0;
            prod_q <= {16'h0000, ma} * {16'h0000, mb};
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vec_cnt++;
        assert (obs === exp) else begin
            err_cnt++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input logic sel, output logic [W-1:0] v);
        rd_sel = sel;
        #1;
        v = rd_data;
    endtask

    // Accept a MULT, then walk it to IDLE checking pulse, busy timing, operand hold and capture
    task automatic do_mult(input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] old_lo,
                           input logic [W-1:0] exp_hi, input logic [W-1:0] exp_lo);
        logic [W-1:0] v;
        int pulses;
        op_valid = 1'b1; op_sel = 2'b00; rs_data = a; rt_data = b;
        tick;
        op_valid = 1'b0; rs_data = 16'h0000; rt_data = 16'h0000;
        chk("start_pulse", mul_start, 1'b1);
        chk("start_busy", busy, 1'b1);
        chk("start_ready", op_ready, 1'b0);
        chk("mul_a", mul_a, a);
        chk("mul_b", mul_b, b);
        pulses = 1;
        for (int k = 1; k <= 19; k++) begin
            tick;
            if (mul_start) pulses++;
            if (k == 17) chk("busy_k17", busy, 1'b1);
            if (k == 18) begin
`ifdef HILO_FWD_EN
                chk("busy_last_wait", busy, 1'b0);
`else
                chk("busy_last_wait", busy, 1'b1);
`endif
            end
            if (k == 19) begin
                chk("busy_capture", busy, 1'b0);
                chk("ready_capture", op_ready, 1'b0);
                chk("mul_a_hold", mul_a, a);
                chk("mul_b_hold", mul_b, b);
                rd(1'b0, v);
`ifdef HILO_FWD_EN
                chk("rd_lo_capture_fwd", v, exp_lo);
`else
                chk("rd_lo_capture", v, old_lo);
`endif
            end
        end
        tick;
        rd(1'b1, v); chk("hi_after", v, exp_hi);
        rd(1'b0, v); chk("lo_after", v, exp_lo);
        chk("ready_after", op_ready, 1'b1);
        chk("busy_after", busy, 1'b0);
        chk("start_pulses", pulses, 1);
    endtask

    initial begin
        logic [W-1:0] v;
        rst_n = 1'b0; op_valid = 1'b0; op_sel = 2'b00;
        rs_data = 16'h0000; rt_data = 16'h0000; rd_sel = 1'b0;

        #12;
        rd(1'b0, v); chk("rst_lo", v, 16'h0000);
        rd(1'b1, v); chk("rst_hi", v, 16'h0000);
        chk("rst_busy", busy, 1'b0);
        chk("rst_start", mul_start, 1'b0);
        chk("rst_mul_a", mul_a, 16'h0000);
        chk("rst_mul_b", mul_b, 16'h0000);
        tick;
        rst_n = 1'b1;
        tick;
        chk("ready_first_edge", op_ready, 1'b1);

        do_mult(16'h0002, 16'h0003, 16'h0000, 16'h0000, 16'h0006);
        do_mult(16'hFFFF, 16'hFFFF, 16'h0006, 16'hFFFE, 16'h0001);

        // MTHI then MTLO back to back
        op_valid = 1'b1; op_sel = 2'b01; rs_data = 16'h1234;
        tick;
        chk("mthi_busy", busy, 1'b0);
        chk("mthi_ready", op_ready, 1'b1);
        op_sel = 2'b10; rs_data = 16'hABCD;
        tick;
        op_valid = 1'b0;
        chk("mtlo_busy", busy, 1'b0);
        rd(1'b1, v); chk("mthi_val", v, 16'h1234);
        rd(1'b0, v); chk("mtlo_val", v, 16'hABCD);

        // MULT 5x7 followed by an MTLO held through the stall
        op_valid = 1'b1; op_sel = 2'b00; rs_data = 16'h0005; rt_data = 16'h0007;
        tick;
        op_sel = 2'b10; rs_data = 16'h5555;
        for (int k = 1; k <= 19; k++) begin
            tick;
            if (k == 10) begin
                chk("stall_ready", op_ready, 1'b0);
                rd(1'b0, v); chk("stall_lo_untouched", v, 16'hABCD);
            end
            if (k == 19) chk("stall_ready_capture", op_ready, 1'b0);
        end
        tick;
        rd(1'b0, v); chk("stall_lo_product", v, 16'h0023);
        rd(1'b1, v); chk("stall_hi_product", v, 16'h0000);
        chk("stall_ready_idle", op_ready, 1'b1);
        tick;
        op_valid = 1'b0;
        rd(1'b0, v); chk("stall_mtlo_taken", v, 16'h5555);

        // Reserved opcode is accepted and discarded
        op_valid = 1'b1; op_sel = 2'b11; rs_data = 16'h9999; rt_data = 16'h9999;
        tick;
        op_valid = 1'b0;
        chk("rsv_start", mul_start, 1'b0);
        chk("rsv_busy", busy, 1'b0);
        chk("rsv_ready", op_ready, 1'b1);
        rd(1'b0, v); chk("rsv_lo", v, 16'h5555);
        rd(1'b1, v); chk("rsv_hi", v, 16'h0000);

        // Reset in mid-WAIT abandons the multiply
        op_valid = 1'b1; op_sel = 2'b00; rs_data = 16'h0100; rt_data = 16'h0100;
        tick;
        op_valid = 1'b0;
        for (int k = 1; k <= 10; k++) tick;
        chk("midwait_busy", busy, 1'b1);
        rst_n = 1'b0;
        #1;
        rd(1'b0, v); chk("midrst_lo", v, 16'h0000);
        rd(1'b1, v); chk("midrst_hi", v, 16'h0000);
        chk("midrst_busy", busy, 1'b0);
        chk("midrst_mul_a", mul_a, 16'h0000);
        tick;
        tick;
        rst_n = 1'b1;
        for (int k = 1; k <= 25; k++) tick;
        rd(1'b0, v); chk("stale_lo", v, 16'h0000);
        rd(1'b1, v); chk("stale_hi", v, 16'h0000);
        chk("stale_busy", busy, 1'b0);
        chk("stale_ready", op_ready, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
